// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multi-cycle memory sequencer: FSM state encoding,
// load/store funct3 codes, the bus request payload and a word-alignment helper.
package cpu_seq_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_ERR   = 3'd5
  } seq_state_e;

  // funct3 encodings; stores reuse the B/H/W codes
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wmask;
  } bus_payload_t;

  // Clear the byte-offset bits of an address
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(STRB_W - 1);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane alignment for one 32-bit memory port.
// Ports:
//   addr_i     byte address of the data access
//   memop_i    funct3 of the load/store
//   wdata_i    store data (rs2)
//   rdata_i    raw bus read word
//   payload_o  word-aligned address, lane-replicated store data, byte enables
//   ld_val_o   selected and sign/zero-extended load value
//   misalign_o access crosses its natural alignment (or funct3 is unsupported)
module mem_lane_align
  import cpu_seq_pkg::*;
(
  input  logic [XLEN-1:0] addr_i,
  input  logic [2:0]      memop_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output bus_payload_t    payload_o,
  output logic [XLEN-1:0] ld_val_o,
  output logic            misalign_o
);

  logic [1:0]  lane;
  logic [15:0] rsel;

  assign lane = addr_i[1:0];
  // Bring the addressed byte/half down to bit 0
  assign rsel = 16'(rdata_i >> {lane, 3'b000});

  // Per-size mask, data replication, extraction and alignment check
  always_comb begin
    payload_o.addr  = word_align(addr_i);
    payload_o.wdata = '0;
    payload_o.wmask = '0;
    ld_val_o        = '0;
    misalign_o      = 1'b0;
    case (memop_i)
      MEMOP_B, MEMOP_BU: begin
        payload_o.wdata = {4{wdata_i[7:0]}};
        payload_o.wmask = STRB_W'(4'b0001 << lane);
        ld_val_o        = (memop_i == MEMOP_BU) ? {24'h0, rsel[7:0]}
                                                : {{24{rsel[7]}}, rsel[7:0]};
      end
      MEMOP_H, MEMOP_HU: begin
        payload_o.wdata = {2{wdata_i[15:0]}};
        payload_o.wmask = STRB_W'(4'b0011 << lane);
        ld_val_o        = (memop_i == MEMOP_HU) ? {16'h0, rsel}
                                                : {{16{rsel[15]}}, rsel};
        misalign_o      = lane[0];
      end
      MEMOP_W: begin
        payload_o.wdata = wdata_i;
        payload_o.wmask = '1;
        ld_val_o        = rdata_i;
        misalign_o      = (lane != 2'b00);
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_mem_sequencer.sv
// Multi-cycle sequencer sharing one memory port between instruction fetch and
// load/store. Fetch, hold the instruction, run the optional data transfer, then
// pulse commit for one cycle. Any bus error, timeout, misalignment or
// conflicting decode parks the core in ERR until reset.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pc, inst                 fetch address in, latched instruction out
//   ld_req, st_req, memop    decoded data-access request
//   mem_addr, mem_wdata      data address and store data
//   ld_data                  extended load result, held through commit
//   commit                   one-cycle architectural write enable
//   bus_*                    single-port memory bus (req/ready handshake)
//   err                      sticky fault, core halted
module cpu_mem_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,  // >= 1
  parameter int unsigned CNT_W   = 8     // 2**CNT_W > TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   inst,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [2:0]        memop,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   ld_data,
  output logic              commit,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [STRB_W-1:0] bus_wmask,
  input  logic              bus_ready,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_err,
  output logic              err
);

  seq_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] ld_data_q, ld_data_d;
  logic            timed_out;

  bus_payload_t    dpay;
  logic [XLEN-1:0] ld_val;
  logic            misalign;

  mem_lane_align u_align (
    .addr_i     (mem_addr),
    .memop_i    (memop),
    .wdata_i    (mem_wdata),
    .rdata_i    (bus_rdata),
    .payload_o  (dpay),
    .ld_val_o   (ld_val),
    .misalign_o (misalign)
  );

  // cnt_inc is the number of cycles this transfer has waited, counting this one;
  // a ready in the same cycle still completes because ready is checked first
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign timed_out = (cnt_inc == CNT_W'(TIMEOUT));

  assign inst    = inst_q;
  assign ld_data = ld_data_q;

  // State and latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      inst_q    <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inst_q    <= inst_d;
      ld_data_q <= ld_data_d;
    end
  end

  // Next-state, timeout counter and data latches
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    inst_d    = inst_q;
    ld_data_d = ld_data_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end
      ST_FETCH: begin
        if (bus_ready) begin
          if (bus_err) begin
            state_d = ST_ERR;
          end else begin
            inst_d  = bus_rdata;
            state_d = ST_EXEC;
          end
        end else if (timed_out) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_EXEC: begin
        cnt_d = '0;
        if (ld_req && st_req) begin
          state_d = ST_ERR;
        end else if (ld_req || st_req) begin
          state_d = misalign ? ST_ERR : ST_MEM;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (bus_ready) begin
          if (bus_err) begin
            state_d = ST_ERR;
          end else begin
            if (ld_req) ld_data_d = ld_val;
            state_d = ST_WB;
          end
        end else if (timed_out) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WB: begin
        cnt_d   = '0;
        state_d = ST_FETCH;
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  // Bus and status outputs decoded from the current state; the datapath holds
  // pc and the data-access inputs stable for the whole transfer
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wmask = '0;
    commit    = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus_req  = 1'b1;
        bus_addr = word_align(pc);
      end
      ST_EXEC: commit = !ld_req && !st_req;
      ST_MEM: begin
        bus_req  = 1'b1;
        bus_we   = st_req;
        bus_addr = dpay.addr;
        if (st_req) begin
          bus_wdata = dpay.wdata;
          bus_wmask = dpay.wmask;
        end
      end
      ST_WB:   commit = 1'b1;
      ST_ERR:  err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Directed + randomized bench for cpu_mem_sequencer. Expected bus payloads and
// load results come from arithmetic reference functions; cycle behaviour is
// checked step by step against the fetch/exec/mem/wb sequence.
module tb_cpu_mem_sequencer;

  localparam int unsigned TIMEOUT = 255;
  localparam int unsigned CNT_W   = 8;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        ld_req, st_req;
  logic [2:0]  memop;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] ld_data;
  logic        commit;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] model_ld;

  cpu_mem_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst),
    .ld_req(ld_req), .st_req(st_req), .memop(memop),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ld_data(ld_data),
    .commit(commit), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int unsigned m_nbytes(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a);
    return a - (a % 4);
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] op, input logic [31:0] a);
    int unsigned n = m_nbytes(op);
    return 4'(((32'd1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] d);
    case (m_nbytes(op))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] r);
    longint unsigned n    = longint'(m_nbytes(op));
    longint unsigned span = 64'd1 << (8 * n);
    longint unsigned v    = (64'(r) >> (8 * (a % 4))) % span;
    if (op != 3'b100 && op != 3'b101 && n < 4 && v >= span / 2)
      v = v + (64'd1 << 32) - span;
    return 32'(v);
  endfunction

  function automatic bit m_misaligned(input logic [2:0] op, input logic [31:0] a);
    return (a % m_nbytes(op)) != 0;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for two cycles, check reset outputs, release and enter FETCH
  task automatic do_reset();
    rst = 1'b1; bus_ready = 1'b0; bus_err = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    step();
    step();
    #1;
    check1("rst_bus_req", bus_req, 1'b0);
    check1("rst_bus_we", bus_we, 1'b0);
    check1("rst_commit", commit, 1'b0);
    check1("rst_err", err, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_ld_data", ld_data, 32'h0);
    check("rst_wmask", {28'h0, bus_wmask}, 32'h0);
    rst = 1'b0;
    model_ld = 32'h0;
    step();
  endtask

  // Entered at a FETCH negedge; leaves at the EXEC negedge with inst checked
  task automatic fetch(input logic [31:0] pc_v, input logic [31:0] word, input int waits);
    bit held = 1'b1;
    pc = pc_v; ld_req = 1'b0; st_req = 1'b0; bus_ready = 1'b0; bus_err = 1'b0;
    #1;
    check1("fetch_req", bus_req, 1'b1);
    check1("fetch_we", bus_we, 1'b0);
    check("fetch_addr", bus_addr, m_addr(pc_v));
    check("fetch_wmask", {28'h0, bus_wmask}, 32'h0);
    check1("fetch_commit", commit, 1'b0);
    for (int i = 0; i < waits; i++) begin
      step();
      if (!(bus_req === 1'b1 && bus_addr === m_addr(pc_v) && commit === 1'b0 && err === 1'b0))
        held = 1'b0;
    end
    if (waits > 0) check1("fetch_hold", held, 1'b1);
    bus_ready = 1'b1;
    bus_rdata = word;
    step();
    bus_ready = 1'b0;
    bus_rdata = $urandom;
    #1;
    check("fetch_inst", inst, word);
  endtask

  // Park in ERR: bus idle, no commit, err high regardless of the bus
  task automatic expect_err(input string tag);
    bit ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_ready = 1'($urandom);
      step();
      if (!(err === 1'b1 && bus_req === 1'b0 && commit === 1'b0)) ok = 1'b0;
    end
    bus_ready = 1'b0;
    check1(tag, ok, 1'b1);
  endtask

  // One full instruction starting at a FETCH negedge, ending at the next FETCH
  // negedge (or in ERR for illegal data accesses)
  task automatic run_instr(input logic [31:0] pc_v, input logic [31:0] word,
                           input logic ld, input logic st, input logic [2:0] op,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int fwait, input int mwait, input logic [31:0] mrd);
    bit held = 1'b1;
    fetch(pc_v, word, fwait);
    ld_req = ld; st_req = st; memop = op; mem_addr = addr; mem_wdata = wd;
    #1;
    check1("exec_commit", commit, !ld && !st);
    check1("exec_bus_req", bus_req, 1'b0);
    step();
    if (!ld && !st) return;
    if ((ld && st) || m_misaligned(op, addr)) begin
      check1("illegal_err", err, 1'b1);
      check1("illegal_no_req", bus_req, 1'b0);
      expect_err("illegal_hold");
      return;
    end
    check1("mem_req", bus_req, 1'b1);
    check1("mem_we", bus_we, st);
    check("mem_addr", bus_addr, m_addr(addr));
    check("mem_wmask", {28'h0, bus_wmask}, st ? {28'h0, m_mask(op, addr)} : 32'h0);
    if (st) check("mem_wdata", bus_wdata, m_wdata(op, wd));
    check1("mem_commit", commit, 1'b0);
    for (int i = 0; i < mwait; i++) begin
      step();
      if (!(bus_req === 1'b1 && bus_addr === m_addr(addr) && bus_we === st && commit === 1'b0))
        held = 1'b0;
    end
    if (mwait > 0) check1("mem_hold", held, 1'b1);
    bus_ready = 1'b1;
    bus_rdata = mrd;
    step();
    bus_ready = 1'b0;
    bus_rdata = $urandom;
    if (ld) model_ld = m_load(op, addr, mrd);
    #1;
    check1("wb_commit", commit, 1'b1);
    check1("wb_bus_req", bus_req, 1'b0);
    check("wb_ld_data", ld_data, model_ld);
    check("wb_inst", inst, word);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  ld_ops [5];
    logic [31:0] pc_m;
    logic [31:0] a;
    logic [2:0]  op;
    int          kind;

    ld_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst = 1'b1; pc = '0; ld_req = 1'b0; st_req = 1'b0; memop = '0;
    mem_addr = '0; mem_wdata = '0; bus_ready = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    model_ld = '0;
    @(negedge clk);
    do_reset();

    // addi at pc 0, zero-wait fetch; next fetch at pc 4
    run_instr(32'h0, 32'h0010_0093, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0);
    // sb 0xA5 to 0x1003
    run_instr(32'h4, 32'h0050_01A3, 1'b0, 1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 0, 0, 32'h0);
    // lb / lbu at 0x2001 with rdata 0x0000_8000
    run_instr(32'h8, 32'h0011_0083, 1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 0, 0, 32'h0000_8000);
    check("lb_value", ld_data, m_load(3'b000, 32'h2001, 32'h0000_8000));
    run_instr(32'hC, 32'h0011_4083, 1'b1, 1'b0, 3'b100, 32'h2001, 32'h0, 0, 1, 32'h0000_8000);
    check("lbu_value", ld_data, m_load(3'b100, 32'h2001, 32'h0000_8000));

    // randomized aligned traffic with random wait states
    pc_m = 32'h10;
    for (int k = 0; k < 40; k++) begin
      kind = int'($urandom_range(0, 2));
      op   = (kind == 1) ? ld_ops[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a    = $urandom;
      a    = a - (a % m_nbytes(op));
      run_instr(pc_m, $urandom, kind == 1, kind == 2, op, a, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      pc_m = pc_m + 4;
    end

    // ready on exactly cycle TIMEOUT of a fetch completes normally
    run_instr(pc_m, 32'h0000_0013, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0,
              int'(TIMEOUT) - 1, 0, 32'h0);
    pc_m = pc_m + 4;
    run_instr(pc_m, 32'h0000_2083, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0,
              int'(TIMEOUT) - 1, 32'hDEAD_BEEF);

    // ready withheld for TIMEOUT fetch cycles -> err
    do_reset();
    pc = 32'h100;
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) step();
    #1;
    check1("to_last_cycle_req", bus_req, 1'b1);
    check1("to_last_cycle_err", err, 1'b0);
    step();
    check1("to_err", err, 1'b1);
    check1("to_no_req", bus_req, 1'b0);
    expect_err("to_hold");

    // lw at 0x2002 is misaligned -> err without a data request; reset recovers
    do_reset();
    run_instr(32'h200, 32'h0001_2083, 1'b1, 1'b0, 3'b010, 32'h2002, 32'h0, 0, 0, 32'h0);
    do_reset();
    run_instr(32'h204, 32'h0000_0013, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0);

    // misaligned sh and conflicting ld+st decode
    run_instr(32'h208, 32'h0011_1023, 1'b0, 1'b1, 3'b001, 32'h3001, 32'h1234, 0, 0, 32'h0);
    do_reset();
    run_instr(32'h20C, 32'h0000_0003, 1'b1, 1'b1, 3'b010, 32'h3000, 32'h0, 0, 0, 32'h0);

    // bus_err on a fetch: no latch, err
    do_reset();
    pc = 32'h300; bus_ready = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1111_1111;
    step();
    bus_ready = 1'b0; bus_err = 1'b0;
    #1;
    check1("berr_err", err, 1'b1);
    check("berr_no_latch", inst, 32'h0);
    expect_err("berr_hold");

    // reset while MEM is waiting: request dropped, no commit, fresh fetch
    do_reset();
    fetch(32'h400, 32'h0000_2083, 0);
    ld_req = 1'b1; memop = 3'b010; mem_addr = 32'h500;
    step();
    check1("rmem_in_mem", bus_req, 1'b1);
    step();
    rst = 1'b1;
    step();
    #1;
    check1("rmem_req_dropped", bus_req, 1'b0);
    check1("rmem_no_commit", commit, 1'b0);
    rst = 1'b0;
    ld_req = 1'b0;
    step();
    #1;
    check1("rmem_refetch_req", bus_req, 1'b1);
    check("rmem_refetch_addr", bus_addr, m_addr(32'h400));
    check1("rmem_refetch_commit", commit, 1'b0);
    model_ld = 32'h0;
    run_instr(32'h400, 32'h0000_0013, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
